// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: access-size encodings and LSU state type.
// lsu_misaligned() is only referenced when LSU_MISALIGN_TRAP_EN is defined.
package mips_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StWrite = 2'd2,
        StFault = 2'd3
    } lsu_state_t;

    // Size 2'b11 is reserved and behaves as a word.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        if (size == SZ_BYTE) begin
            return 1'b0;
        end else if (size == SZ_HALF) begin
            return addr_lo[0];
        end else begin
            return addr_lo != 2'b00;
        end
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic for the LSU: little-endian load extraction with
// sign/zero extension, and byte-lane merge for sub-word read-modify-write.
module lsu_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [4:0]  byte_shift;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sign_bit;

    always_comb begin
        byte_shift  = {addr_lo_i, 3'b000};
        byte_lane   = rdata_i[byte_shift +: 8];
        // Half lane ignores addr[0]; misalignment is handled by the caller.
        half_lane   = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        sign_bit    = 1'b0;
        load_data_o = rdata_i;
        merged_o    = rdata_i;
        case (size_i)
            SZ_BYTE: begin
                sign_bit                  = ~unsigned_i & byte_lane[7];
                load_data_o               = {{24{sign_bit}}, byte_lane};
                merged_o[byte_shift +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                sign_bit    = ~unsigned_i & half_lane[15];
                load_data_o = {{16{sign_bit}}, half_lane};
                if (addr_lo_i[1]) begin
                    merged_o[31:16] = wdata_i[15:0];
                end else begin
                    merged_o[15:0] = wdata_i[15:0];
                end
            end
            default: begin
                load_data_o = rdata_i;
                merged_o    = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/lsu_subword.sv
// Load/store unit in front of a word-only data memory; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of ignoring low bits.
module lsu_subword
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              misaligned,
    output logic              stall,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_t        state_q, state_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              misaligned_q, misaligned_d;

    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merged;

    lsu_lane_align u_lane_align (
        .size_i      (size_q),
        .addr_lo_i   (addr_q[1:0]),
        .unsigned_i  (unsigned_q),
        .rdata_i     (mem_rdata),
        .wdata_i     (wdata_q),
        .load_data_o (load_data),
        .merged_o    (merged)
    );

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        rdata_d      = '0;
        misaligned_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    write_d    = req_write;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (lsu_misaligned(req_size, req_addr[1:0])) begin
                        state_d = StFault;
                    end else
`endif
                    if (!req_write || !req_size[1]) begin
                        state_d = StRead;
                    end else begin
                        state_d = StWrite;
                    end
                end
            end
            StRead: begin
                if (!write_q) begin
                    rdata_d      = load_data;
                    resp_valid_d = 1'b1;
                    state_d      = StIdle;
                end else begin
                    // Captured word now carries the store lane; WRITE sends it back.
                    wdata_d = merged;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                resp_valid_d = 1'b1;
                state_d      = StIdle;
            end
            StFault: begin
                resp_valid_d = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                misaligned_d = 1'b1;
`endif
                state_d      = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign stall      = (state_q != StIdle);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign misaligned = misaligned_q;
    // Gated by rst so a reset landing in WRITE cannot commit a half-finished store.
    assign mem_write  = (state_q == StWrite) && !rst;
    assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata  = (state_q == StWrite) ? wdata_q : '0;

endmodule
